io_regs_pwm: RTL and testbench
==============================

IO_REGS_PWM -- requirements
Module: io_regs_pwm

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..16).
REQ-002 Parameter CH_W, default 8, bits per channel (1..32).
REQ-003 Parameter CH_RESET, default all zeros, NUM_CH*CH_W-bit reset value; channel k occupies bits [k*CH_W +: CH_W].
REQ-004 Parameter PWM_DIV, default 16, system clocks per PWM phase step (>=1).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 sel  input  1  block selected by upstream address decode.
REQ-008 word_addr  input  6  word index within the block.
REQ-009 rstrb  input  1  read strobe, one-cycle pulse.
REQ-010 wdata  input  32  write data.
REQ-011 wmask  input  4  byte write enables; write when sel and any bit set.
REQ-012 rdata  output  32  registered read data.
REQ-013 rbusy  output  1  read busy; tied 0.
REQ-014 ch_out  output  NUM_CH*CH_W  channel outputs to pins.

Function
REQ-015 Map: word 2k = VALUE[k] (bits [CH_W-1:0]); word 2k+1 = MODE[k] (bit0 pwm_en, bits[15:8] duty); word 63 = ID, read-only {8'h1, 8'(NUM_CH), 8'(CH_W), 8'h0}.
REQ-016 Writes take effect at the clock edge of the strobe; only bytes with wmask set update; bits beyond CH_W and unused MODE bits are discarded.
REQ-017 Writes to ID, unmapped words, or with sel=0 have no effect.
REQ-018 Read: rdata valid on the cycle after sel&rstrb, held until next read; unmapped words return 0; unused bits read 0.
REQ-019 Read and write to the same word in one cycle: rdata returns the pre-write value.
REQ-020 Prescaler counts 0..PWM_DIV-1 then wraps; at wrap, 8-bit phase increments, wrapping 255->0.
REQ-021 pwm_en=0: channel output = VALUE[k] continuously.
REQ-022 pwm_en=1: channel output = VALUE[k] when phase < duty, else 0; duty 0 gives constant 0; duty 255 gives 255/256 on-time.
REQ-023 ch_out is registered: a VALUE/MODE write is visible on ch_out one cycle after the write edge.
REQ-024 Prescaler and phase are shared by all channels and unaffected by register writes.

Reset
REQ-025 While reset_n=0 at a clock edge: VALUE[k] <= CH_RESET slice k, MODE[k] <= 0, prescaler <= 0, phase <= 0, rdata <= 0, ch_out <= CH_RESET.
REQ-026 Strobes during reset are ignored; reset asserted mid-PWM period returns to phase 0 with outputs static.
REQ-027 First accepted access is the first edge with reset_n=1.

Structure
REQ-028 Register offsets (MODE bit positions, ID word 63, ID version byte) live in shared package io_pkg.
REQ-029 Single sub-module pwm_timebase (prescaler + phase counter, outputs phase) instantiated once; per-channel compare logic in the top module via generate.
REQ-030 Top-level decoder drives sel; block must not decode address bits above word_addr.

Verification
REQ-031 Reset with CH_RESET=32'h84FF_7F00 (NUM_CH=4, CH_W=8) -> ch_out=32'h84FF_7F00, rdata=0 after first post-reset clock.
REQ-032 Write VALUE[1]=32'hAB with wmask=4'b0001 -> next cycle ch_out[15:8]=8'hAB; then wmask=4'b0010 data 32'h1200 -> value unchanged 8'hAB (bits beyond CH_W dropped).
REQ-033 Read word 63 -> rdata=32'h0104_0800 one cycle later; read word 40 -> rdata=0.
REQ-034 Same-cycle read+write VALUE[0] 0x11->0x22 -> rdata=0x11, later read returns 0x22.
REQ-035 PWM_DIV=2, VALUE[2]=8'hFF, MODE[2]={duty=64, en=1} -> over 512 clocks ch_out[23:16]=8'hFF for exactly 128 cycles, 0 otherwise.
REQ-036 Assert reset_n=0 mid-PWM for one cycle -> MODE cleared, ch_out returns to CH_RESET next cycle, phase restarts at 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared register map constants and helpers for the io_regs_pwm block.
package io_pkg;

  localparam int unsigned MODE_EN_BIT   = 0;
  localparam int unsigned MODE_DUTY_LSB = 8;
  localparam logic [5:0]  ID_WORD       = 6'd63;
  localparam logic [7:0]  ID_VERSION    = 8'h01;

  typedef struct packed {
    logic [7:0] duty;
    logic       pwm_en;
  } mode_t;

  function automatic logic [31:0] mode_to_word(input mode_t m);
    logic [31:0] w;
    w                         = '0;
    w[MODE_EN_BIT]            = m.pwm_en;
    w[MODE_DUTY_LSB +: 8]     = m.duty;
    return w;
  endfunction

  // Replaces only the bytes whose mask bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/io_regs_pwm_if.sv
// Word-addressed register bus between the upstream decoder and io_regs_pwm.
interface io_regs_pwm_if;
  logic        sel;
  logic [5:0]  word_addr;
  logic        rstrb;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        rbusy;

  modport master (output sel, word_addr, rstrb, wdata, wmask, input rdata, rbusy);
  modport slave  (input sel, word_addr, rstrb, wdata, wmask, output rdata, rbusy);
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler of PWM_DIV clocks driving an 8-bit wrapping phase.
module pwm_timebase #(
  parameter int unsigned PWM_DIV = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] phase
);

  localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    phase_q, phase_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    phase_d = phase_q;
    if (presc_q == PW'(PWM_DIV - 1)) begin
      presc_d = '0;
      phase_d = phase_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      phase_q <= '0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/io_regs_pwm.sv
// Per-channel VALUE/MODE registers with read-back, driving static or PWM-gated pin outputs.
module io_regs_pwm
  import io_pkg::*;
#(
  parameter int unsigned             NUM_CH   = 4,
  parameter int unsigned             CH_W     = 8,
  parameter logic [NUM_CH*CH_W-1:0]  CH_RESET = '0,
  parameter int unsigned             PWM_DIV  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  io_regs_pwm_if.slave           bus,
  output logic [NUM_CH*CH_W-1:0] ch_out
);

  logic [CH_W-1:0]        value_q [NUM_CH];
  logic [CH_W-1:0]        value_d [NUM_CH];
  mode_t                  mode_q  [NUM_CH];
  mode_t                  mode_d  [NUM_CH];
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_CH*CH_W-1:0] ch_out_q, ch_out_d;
  logic [7:0]             phase;
  logic [31:0]            merged;

  logic [4:0] ch_idx;
  logic       is_mode;
  logic       rd_en;
  logic       wr_en;

  localparam logic [31:0] ID_VALUE = {ID_VERSION, 8'(NUM_CH), 8'(CH_W), 8'h00};

  assign ch_idx  = bus.word_addr[5:1];
  assign is_mode = bus.word_addr[0];
  assign rd_en   = bus.sel && bus.rstrb;
  assign wr_en   = bus.sel && (|bus.wmask);

  pwm_timebase #(.PWM_DIV(PWM_DIV)) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .phase   (phase)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    value_d = value_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    merged  = '0;

    // Reads sample the _q state, so a same-cycle write returns the old value.
    if (rd_en) begin
      rdata_d = (bus.word_addr == ID_WORD) ? ID_VALUE : '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_idx == 5'(k)) rdata_d = is_mode ? mode_to_word(mode_q[k]) : 32'(value_q[k]);
      end
    end

    if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_idx == 5'(k)) begin
          if (is_mode) begin
            merged           = byte_merge(mode_to_word(mode_q[k]), bus.wdata, bus.wmask);
            mode_d[k].pwm_en = merged[MODE_EN_BIT];
            mode_d[k].duty   = merged[MODE_DUTY_LSB +: 8];
          end else begin
            merged     = byte_merge(32'(value_q[k]), bus.wdata, bus.wmask);
            value_d[k] = merged[CH_W-1:0];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_out_d[k*CH_W +: CH_W] =
      (!mode_q[k].pwm_en || (phase < mode_q[k].duty)) ? value_q[k] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the register file is a handful of flops, not a RAM, so every entry is reset.
      for (int k = 0; k < NUM_CH; k++) begin
        value_q[k] <= CH_RESET[k*CH_W +: CH_W];
        mode_q[k]  <= '0;
      end
      rdata_q  <= '0;
      ch_out_q <= CH_RESET;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      value_q  <= value_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      ch_out_q <= ch_out_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rbusy = 1'b0;
  assign ch_out    = ch_out_q;

endmodule

// File: tb/tb_io_regs_pwm.sv
// Randomized bench for io_regs_pwm against an abstract register/PWM model.
module tb_io_regs_pwm;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_W    = 8;
  localparam int unsigned PWM_DIV = 2;
  localparam logic [31:0] RST_VAL = 32'h84FF_7F00;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] ch_out;

  io_regs_pwm_if bus ();

  io_regs_pwm #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CH_RESET(RST_VAL), .PWM_DIV(PWM_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .ch_out  (ch_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: channel registers, plus a count of clocks since reset from which phase is derived.
  logic [7:0]  m_val  [NUM_CH];
  logic        m_en   [NUM_CH];
  logic [7:0]  m_duty [NUM_CH];
  int unsigned m_tick;
  logic [31:0] m_rdata;
  logic [31:0] m_ch_out;

  function automatic logic [31:0] model_out();
    logic [31:0] o;
    int unsigned ph;
    o  = '0;
    ph = (m_tick / PWM_DIV) % 256;
    for (int k = 0; k < NUM_CH; k++)
      if (!m_en[k] || ph < int'(m_duty[k])) o[k*8 +: 8] = m_val[k];
    return o;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int unsigned ai;
    ai = int'(a);
    if (ai == 63) return 32'h0104_0800;
    if (ai >= 2 * NUM_CH) return 32'h0;
    if (ai % 2 == 0) return {24'h0, m_val[ai/2]};
    return {16'h0, m_duty[ai/2], 7'h0, m_en[ai/2]};
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    int unsigned ai;
    logic [31:0] w;
    ai = int'(a);
    if (ai >= 2 * NUM_CH) return;
    w = (ai % 2 == 0) ? {24'h0, m_val[ai/2]} : {16'h0, m_duty[ai/2], 7'h0, m_en[ai/2]};
    for (int b = 0; b < 4; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    if (ai % 2 == 0) m_val[ai/2] = w[7:0];
    else begin
      m_en[ai/2]   = w[0];
      m_duty[ai/2] = w[15:8];
    end
  endtask

  // One clock edge: DUT and model advance together, then settle 1 time unit past the edge.
  task automatic tick();
    logic [31:0] nxt;
    @(posedge clk);
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_val[k]  = RST_VAL[k*8 +: 8];
        m_en[k]   = 1'b0;
        m_duty[k] = 8'h0;
      end
      m_tick   = 0;
      m_rdata  = '0;
      m_ch_out = RST_VAL;
    end else begin
      nxt = model_out();
      if (bus.sel && bus.rstrb) m_rdata = model_read(bus.word_addr);
      if (bus.sel && (|bus.wmask)) model_write(bus.word_addr, bus.wdata, bus.wmask);
      m_ch_out = nxt;
      m_tick++;
    end
    #1;
  endtask

  task automatic access(input logic s, input logic [5:0] a, input logic rd,
                        input logic [31:0] d, input logic [3:0] m);
    bus.sel = s; bus.word_addr = a; bus.rstrb = rd; bus.wdata = d; bus.wmask = m;
    tick();
    bus.sel = 1'b0; bus.rstrb = 1'b0; bus.wmask = 4'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    access(1'b1, 6'd0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    tick();
    n_cmp++; if (ch_out !== RST_VAL) begin n_mis++; $display("FAIL rst_ch_out: got %h want %h", ch_out, RST_VAL); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_mis++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (ch_out !== RST_VAL) begin n_mis++; $display("FAIL rst_first_clk: got %h want %h", ch_out, RST_VAL); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_mis++; $display("FAIL rst_first_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if (bus.rbusy !== 1'b0) begin n_mis++; $display("FAIL rbusy: got %b want 0", bus.rbusy); end
  endtask

  task automatic test_value_write();
    access(1'b1, 6'd2, 1'b0, 32'h0000_00AB, 4'b0001);
    tick();
    n_cmp++; if (ch_out[15:8] !== 8'hAB) begin n_mis++; $display("FAIL val_write: got %h want ab", ch_out[15:8]); end
    access(1'b1, 6'd2, 1'b0, 32'h0000_1200, 4'b0010);
    tick();
    n_cmp++; if (ch_out[15:8] !== 8'hAB) begin n_mis++; $display("FAIL val_wide_drop: got %h want ab", ch_out[15:8]); end
    n_cmp++; if (ch_out !== m_ch_out) begin n_mis++; $display("FAIL val_ch_out: got %h want %h", ch_out, m_ch_out); end
    access(1'b1, 6'd2, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0000_00AB) begin n_mis++; $display("FAIL val_readback: got %h want ab", bus.rdata); end
  endtask

  task automatic test_id_unmapped();
    access(1'b1, 6'd63, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0104_0800) begin n_mis++; $display("FAIL id_read: got %h want 01040800", bus.rdata); end
    tick();
    n_cmp++; if (bus.rdata !== 32'h0104_0800) begin n_mis++; $display("FAIL rdata_hold: got %h want 01040800", bus.rdata); end
    access(1'b1, 6'd40, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0) begin n_mis++; $display("FAIL unmapped_read: got %h want 0", bus.rdata); end
    access(1'b1, 6'd63, 1'b0, $urandom, 4'hF);
    access(1'b1, 6'd40, 1'b0, $urandom, 4'hF);
    access(1'b0, 6'd2,  1'b0, 32'h0000_0055, 4'hF);
    access(1'b1, 6'd2,  1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0000_00AB) begin n_mis++; $display("FAIL nosel_write: got %h want ab", bus.rdata); end
    access(1'b1, 6'd63, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0104_0800) begin n_mis++; $display("FAIL id_readonly: got %h want 01040800", bus.rdata); end
  endtask

  task automatic test_read_write_same();
    access(1'b1, 6'd0, 1'b0, 32'h11, 4'b0001);
    access(1'b1, 6'd0, 1'b1, 32'h22, 4'b0001);
    n_cmp++; if (bus.rdata !== 32'h11) begin n_mis++; $display("FAIL rw_same_old: got %h want 11", bus.rdata); end
    access(1'b1, 6'd0, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h22) begin n_mis++; $display("FAIL rw_same_new: got %h want 22", bus.rdata); end
  endtask

  task automatic test_random();
    int unsigned r;
    logic [5:0] a;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 9) a = 6'(r);
      else if (r == 10) a = 6'd63;
      else a = 6'($urandom_range(0, 63));
      access(($urandom_range(0, 7) != 0), a, 1'($urandom), $urandom, 4'($urandom));
      n_cmp++; if (bus.rdata !== m_rdata) begin n_mis++; $display("FAIL rand_rdata[%0d] a=%0d: got %h want %h", i, a, bus.rdata, m_rdata); end
      n_cmp++; if (ch_out !== m_ch_out) begin n_mis++; $display("FAIL rand_ch_out[%0d]: got %h want %h", i, ch_out, m_ch_out); end
    end
  endtask

  task automatic test_pwm();
    int on_cnt;
    on_cnt = 0;
    access(1'b1, 6'd4, 1'b0, 32'h0000_00FF, 4'b0001);
    access(1'b1, 6'd5, 1'b0, 32'h0000_4001, 4'b0011);
    tick();
    for (int i = 0; i < 512; i++) begin
      tick();
      if (ch_out[23:16] == 8'hFF) on_cnt++;
      n_cmp++; if (ch_out !== m_ch_out) begin n_mis++; $display("FAIL pwm_ch_out[%0d]: got %h want %h", i, ch_out, m_ch_out); end
    end
    n_cmp++; if (on_cnt !== 128) begin n_mis++; $display("FAIL pwm_on_count: got %0d want 128", on_cnt); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 37; i++) tick();
    reset_n = 1'b0;
    access(1'b1, 6'd2, 1'b0, 32'h0000_0033, 4'hF);
    n_cmp++; if (ch_out !== RST_VAL) begin n_mis++; $display("FAIL mid_rst_ch_out: got %h want %h", ch_out, RST_VAL); end
    reset_n = 1'b1;
    access(1'b1, 6'd3, 1'b0, 32'h0000_0101, 4'b0011);
    n_cmp++; if (ch_out !== RST_VAL) begin n_mis++; $display("FAIL mid_rst_static: got %h want %h", ch_out, RST_VAL); end
    tick();
    n_cmp++; if (ch_out[15:8] !== 8'h7F) begin n_mis++; $display("FAIL phase0_on: got %h want 7f", ch_out[15:8]); end
    tick();
    n_cmp++; if (ch_out[15:8] !== 8'h00) begin n_mis++; $display("FAIL phase1_off: got %h want 00", ch_out[15:8]); end
    n_cmp++; if (ch_out[23:16] !== 8'hFF) begin n_mis++; $display("FAIL mode_cleared_out: got %h want ff", ch_out[23:16]); end
    access(1'b1, 6'd5, 1'b1, 32'h0, 4'h0);
    n_cmp++; if (bus.rdata !== 32'h0) begin n_mis++; $display("FAIL mode_cleared_read: got %h want 0", bus.rdata); end
    for (int i = 0; i < 600; i++) begin
      tick();
      n_cmp++; if (ch_out !== m_ch_out) begin n_mis++; $display("FAIL post_rst_ch_out[%0d]: got %h want %h", i, ch_out, m_ch_out); end
    end
  endtask

  initial begin
    bus.sel = 1'b0; bus.word_addr = '0; bus.rstrb = 1'b0; bus.wdata = '0; bus.wmask = '0;
    m_tick = 0; m_rdata = '0; m_ch_out = RST_VAL;
    test_reset();
    test_value_write();
    test_id_unmapped();
    test_read_write_same();
    test_random();
    test_pwm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
